// File: rtl/stream_demux_nb.sv
// -----------------------------------------------------------------------------
// stream_demux_nb
//   Registered 1-to-NO_OUTS demultiplexer with valid/ready handshakes.
//   An input word goes to the output channel named by in_sel. Each channel
//   has a one-entry register slot. A slot that is popped can be refilled in
//   the same cycle, so each channel can carry one word per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   combinational; the block accepts the word this cycle
//   in_data    input word (N bits)
//   in_sel     destination channel index (SEL_W bits)
//   out_valid  bit k: slot k holds a word
//   out_ready  bit k: consumer k takes the word this cycle
//   out_data   flattened; channel k is bits [k*N +: N]
//   err_oob    sticky; a word with an out-of-range select was accepted
//   drop_cnt   (only with STREAM_DEMUX_DROP_CNT_EN) saturating count of
//              out-of-range words that were dropped
//
// Optional feature macro: STREAM_DEMUX_DROP_CNT_EN
// -----------------------------------------------------------------------------
module stream_demux_nb #(
  parameter int unsigned NO_OUTS = 4,
  parameter int unsigned N       = 4,
  parameter int unsigned SEL_W   = $clog2(NO_OUTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [SEL_W-1:0]     in_sel,
  output logic [NO_OUTS-1:0]   out_valid,
  input  logic [NO_OUTS-1:0]   out_ready,
  output logic [NO_OUTS*N-1:0] out_data,
  output logic                 err_oob
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]           drop_cnt
`endif
);

  localparam int unsigned DW = NO_OUTS * N;

  logic [NO_OUTS-1:0] full_q, full_d;
  logic [DW-1:0]      data_q, data_d;
  logic               err_q, err_d;

  logic in_range;
  logic sel_full;
  logic sel_rdy;
  logic push;
  logic drop;

  // Decode the select: range check and the addressed slot's state.
  // Matching against every legal index avoids indexing past NO_OUTS when
  // NO_OUTS is not a power of two.
  always_comb begin : sel_decode
    in_range = 1'b0;
    sel_full = 1'b0;
    sel_rdy  = 1'b0;
    for (int k = 0; k < int'(NO_OUTS); k++) begin
      if (in_sel == SEL_W'(k)) begin
        in_range = 1'b1;
        sel_full = full_q[k];
        sel_rdy  = out_ready[k];
      end
    end
    // Out-of-range words are always accepted and then dropped.
    in_ready = in_range ? (~sel_full | sel_rdy) : 1'b1;
  end

  // Slot next-state: pops first, then a push overrides its own slot.
  always_comb begin : slot_next
    full_d = full_q & ~out_ready;
    data_d = data_q;
    err_d  = err_q;
    push   = in_valid & in_ready & in_range;
    drop   = in_valid & ~in_range;
    for (int k = 0; k < int'(NO_OUTS); k++) begin
      if (push && (in_sel == SEL_W'(k))) begin
        full_d[k]         = 1'b1;
        data_d[k*N +: N]  = in_data;
      end
    end
    if (drop) begin
      err_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin : slot_regs
    if (!rst_n) begin
      full_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign err_oob   = err_q;

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter.
  always_comb begin : drop_cnt_next
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : drop_cnt_reg
    if (!rst_n) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_nb.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_nb
//   Bench for stream_demux_nb. Two instances share the same stimulus:
//   d4 (NO_OUTS=4) and d3 (NO_OUTS=3, so select 3 is out of range).
//   A behavioural model of slots, sticky error and drop count predicts
//   in_ready and all outputs.
// -----------------------------------------------------------------------------
module tb_stream_demux_nb;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_sel;
  logic [3:0]  in_data;
  logic [3:0]  out_ready;

  logic        in_ready4, in_ready3;
  logic [3:0]  out_valid4;
  logic [2:0]  out_valid3;
  logic [15:0] out_data4;
  logic [11:0] out_data3;
  logic        err4, err3;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [7:0]  drop4, drop3;
`endif

  stream_demux_nb #(.NO_OUTS(4), .N(4)) d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .err_oob(err4)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    , .drop_cnt(drop4)
`endif
  );

  stream_demux_nb #(.NO_OUTS(3), .N(4)) d3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid3), .out_ready(out_ready[2:0]),
    .out_data(out_data3), .err_oob(err3)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    , .drop_cnt(drop3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: index 0 -> d4, index 1 -> d3.
  int       nouts [2] = '{4, 3};
  bit       m_full [2][4];
  bit [3:0] m_data [2][4];
  bit       m_err  [2];
  int       m_drop [2];

  function automatic bit exp_ready(int d);
    int s = int'(in_sel);
    if (s < nouts[d]) return !m_full[d][s] || out_ready[s];
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        m_full[d][k] = 1'b0;
        m_data[d][k] = 4'h0;
      end
      m_err[d]  = 1'b0;
      m_drop[d] = 0;
    end
  endtask

  // Applies one clock edge worth of the spec's rules to the model.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit acc = in_valid && exp_ready(d);
      int s   = int'(in_sel);
      for (int k = 0; k < nouts[d]; k++)
        if (m_full[d][k] && out_ready[k]) m_full[d][k] = 1'b0;
      if (acc && s < nouts[d]) begin
        m_full[d][s] = 1'b1;
        m_data[d][s] = in_data;
      end else if (acc) begin
        m_err[d] = 1'b1;
        if (m_drop[d] < 255) m_drop[d]++;
      end
    end
  endtask

  task automatic check_outs();
    logic [63:0] ev [2];
    logic [63:0] ed [2];
    for (int d = 0; d < 2; d++) begin
      ev[d] = '0;
      ed[d] = '0;
      for (int k = 0; k < nouts[d]; k++) begin
        ev[d][k] = m_full[d][k];
        ed[d] = ed[d] | (64'(m_data[d][k]) << (4 * k));
      end
    end
    check("valid4", 64'(out_valid4), ev[0]);
    check("data4",  64'(out_data4),  ed[0]);
    check("err4",   64'(err4),       64'(m_err[0]));
    check("valid3", 64'(out_valid3), ev[1]);
    check("data3",  64'(out_data3),  ed[1]);
    check("err3",   64'(err3),       64'(m_err[1]));
`ifdef STREAM_DEMUX_DROP_CNT_EN
    check("drop4",  64'(drop4),      64'(m_drop[0]));
    check("drop3",  64'(drop3),      64'(m_drop[1]));
`endif
  endtask

  task automatic check_ready();
    check("ready4", 64'(in_ready4), 64'(exp_ready(0)));
    check("ready3", 64'(in_ready3), 64'(exp_ready(1)));
  endtask

  // Inputs are set just after a negedge; this checks in_ready, clocks once
  // and checks the outputs at the following negedge.
  task automatic cyc();
    #1;
    check_ready();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic drive(input bit v, input int sel, input int data, input int rdy);
    in_valid  = v;
    in_sel    = 2'(sel);
    in_data   = 4'(data);
    out_ready = 4'(rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    do_reset();

    // Basic route: channel 2 gets 4'hA and holds it while stalled.
    drive(1, 2, 4'hA, 0);
    cyc();
    check("route_valid", 64'(out_valid4), 64'(4'b0100));
    check("route_data", 64'(out_data4[11:8]), 64'(4'hA));
    drive(1, 2, 4'h3, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_ready", 64'(in_ready4), 64'(1'b0));
      cyc();
      check("hold_data", 64'(out_data4[11:8]), 64'(4'hA));
    end

    // Backpressure release: simultaneous pop and push on channel 2.
    drive(1, 2, 4'h5, 4'b0100);
    #1;
    check("release_ready", 64'(in_ready4), 64'(1'b1));
    cyc();
    check("release_data", 64'(out_data4[11:8]), 64'(4'h5));
    check("release_valid", 64'(out_valid4[2]), 64'(1'b1));

    // Asynchronous reset mid-cycle with slot 2 full.
    drive(0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 64'(out_valid4), 64'(0));
    check("rst_data", 64'(out_data4), 64'(0));
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with all consumers ready: no bubbles.
    for (int i = 0; i < 8; i++) begin
      drive(1, i % 4, i + 1, 4'hF);
      #1;
      check("stream_ready", 64'(in_ready4), 64'(1'b1));
      cyc();
      check("stream_data", 64'(out_data4[(i % 4) * 4 +: 4]), 64'(i + 1));
    end
    drive(0, 0, 0, 4'hF);
    cyc();

    // Out-of-range select on the 3-channel instance.
    do_reset();
    drive(1, 3, 4'h7, 0);
    #1;
    check("oob_ready", 64'(in_ready3), 64'(1'b1));
    cyc();
    check("oob_err", 64'(err3), 64'(1'b1));
    check("oob_valid", 64'(out_valid3), 64'(0));
    for (int i = 0; i < 300; i++) begin
      drive(1, 3, i, 4'hF);
      cyc();
    end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    check("drop_sat", 64'(drop3), 64'(255));
`endif

    // Independent pop: slots 0 and 1 drain while channel 3 is pushed.
    do_reset();
    drive(1, 0, 4'h1, 0); cyc();
    drive(1, 1, 4'h2, 0); cyc();
    drive(1, 3, 4'h9, 4'b0011);
    cyc();
    check("indep_valid", 64'(out_valid4), 64'(4'b1000));

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        drive(0, 0, 0, 0);
        do_reset();
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3),
            $urandom_range(0, 15), $urandom_range(0, 15));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux_nb.md
Name: stream_demux_nb

Overview:
- Registered 1-to-NO_OUTS demultiplexer with valid/ready handshakes; the distributing counterpart of the generic N-bit mux.
- Routes one input word to the output channel named by its select field, through a one-entry register slot per output.
- Used in the pipeline wherever one producer feeds several consumers, e.g. fanning write-back results or decoded ops out to per-unit queues.

Parameters:
- NO_OUTS, 4, number of output channels; legal range 2..64.
- N, 4, data width in bits.
- SEL_W, $clog2(NO_OUTS), select width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_data  input  N  input word.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  NO_OUTS  bit k: slot k holds a word.
- out_ready  input  NO_OUTS  bit k: consumer k takes the word this cycle.
- out_data  output  NO_OUTS*N  flattened; channel k is bits [k*N +: N].
- err_oob  output  1  sticky flag; an out-of-range select was accepted.

Behaviour:
- Reset is asynchronous on the rst_n falling edge. While rst_n=0: out_valid=0, out_data=0, err_oob=0.
- in_ready is combinational. Reset does not force it; it follows the slot and select rules below.
- Reset mid-transfer discards all held words with no completion.
- Slot k state is full[k], equal to out_valid[k], plus a data register.
- Select in range (in_sel < NO_OUTS): in_ready = !full[in_sel] | out_ready[in_sel].
- Select out of range (only possible when NO_OUTS is not a power of two): in_ready=1. The word is dropped and err_oob is set on the next edge.
- Push: in_valid & in_ready & in-range select. On the next edge the word loads into slot in_sel and full[in_sel] is set.
- Latency: accepted in cycle t, out_valid[k]=1 with the data in cycle t+1.
- Pop: out_valid[k] & out_ready[k] clears full[k] on the next edge, unless a push to k happens in the same cycle.
- Push and pop on the same slot in one cycle: the slot stays full with the new word. This gives one word per cycle per channel.
- Pushes to one channel and pops on other channels in the same cycle are independent.
- Hold rule: while out_valid[k]=1 and out_ready[k]=0, out_data[k] stays stable.
- Data in a non-full slot keeps its last value. Consumers ignore it.
- Only one channel can be pushed per cycle. All channels may pop simultaneously.
- in_ready may depend on in_sel combinationally. It never depends on in_valid.
- No combinational path from in_data to out_data.
- err_oob is cleared only by reset.

Optional Feature:
- Macro: STREAM_DEMUX_DROP_CNT_EN.
- Defined: adds output port drop_cnt, 8 bits, reset 0. It increments once per accepted out-of-range word and saturates at 255.
- Undefined: the port and its logic are absent. err_oob alone reports drops.

Test Plan:
- Reset: assert rst_n=0 mid-stream with slot 2 full -> out_valid=4'b0000, out_data=0, err_oob=0 immediately, with no clock edge needed.
- Basic route (NO_OUTS=4, N=4): in_sel=2, in_data=4'hA, all out_ready=0 -> next cycle out_valid=4'b0100, channel 2 = 4'hA. Held for 5 cycles with in_ready=0 while in_sel=2.
- Backpressure release: slot 2 full, out_ready[2]=1 with a new push of 4'h5 to channel 2 -> in_ready=1. Next cycle channel 2 = 4'h5 and out_valid[2] stays 1.
- Streaming: in_valid=1 for 8 cycles, in_sel=0..3 repeating, data 1..8, all out_ready=1 -> each channel shows its words one cycle after acceptance, with no bubbles and no loss.
- Out-of-range (NO_OUTS=3): in_sel=3, in_valid=1 -> in_ready=1, no out_valid change, err_oob=1 next cycle. With STREAM_DEMUX_DROP_CNT_EN, drop_cnt=1; after 300 such words drop_cnt=255.
- Independent pop: slots 0 and 1 full, out_ready=2'b11, push to channel 3 -> next cycle out_valid=4'b1000.
